// File: rtl/wb_seq_if.sv
// Writeback sequencer bus: ALU and load result sources,
// the register-file write port, and forwarding queries.
interface wb_seq_if #(
  parameter int CW = 3
);
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          we3;
  logic [4:0]    a3;
  logic [31:0]   wd3;
  logic [4:0]    q1;
  logic [4:0]    q2;
  logic          fwd1_hit;
  logic [31:0]   fwd1_data;
  logic          fwd2_hit;
  logic [31:0]   fwd2_data;
  logic [CW-1:0] pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output q1, q2,
    input  ld_ready, we3, a3, wd3,
    input  fwd1_hit, fwd1_data,
    input  fwd2_hit, fwd2_data,
    input  pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  q1, q2,
    output ld_ready, we3, a3, wd3,
    output fwd1_hit, fwd1_data,
    output fwd2_hit, fwd2_data,
    output pending
  );
endinterface

// File: rtl/wb_sequencer.sv
// Writeback sequencer: ALU results win the write port,
// loads queue in a FIFO; pending results are forwarded.
module wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic   clk,
  input logic   reset,
  wb_seq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [4:0]       rd_q  [DEPTH];
  logic [31:0]      dat_q [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [AW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;

  logic             full, empty;
  logic             push, pop, alu_wr;
  logic [32:0]      f1, f2;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign alu_wr = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign push   = bus.ld_valid && !full
               && (bus.ld_rd != 5'd0);
  assign pop    = !bus.alu_valid && !empty;
  assign cnt_d  = cnt_q + CW'(push) - CW'(pop);

  // Next write-port value: ALU first, else a live FIFO head
  always_comb begin
    we3_d = 1'b0;
    a3_d  = '0;
    wd3_d = '0;
    unique case (1'b1)
      alu_wr: begin
        we3_d = 1'b1;
        a3_d  = bus.alu_rd;
        wd3_d = bus.alu_data;
      end
      (pop && !kill_q[rp_q]): begin
        we3_d = 1'b1;
        a3_d  = rd_q[rp_q];
        wd3_d = dat_q[rp_q];
      end
      default: ;
    endcase
  end

  // Write-port register and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q <= 1'b0;
      a3_q  <= '0;
      wd3_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      cnt_q <= cnt_d;
      if (push) wp_q <= wp_q + AW'(1);
      if (pop)  rp_q <= rp_q + AW'(1);
    end
  end

  // Entry storage; a younger ALU write kills same-rd entries
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) begin
      if (alu_wr && rd_q[j] == bus.alu_rd)
        kill_q[j] <= 1'b1;
    end
    if (push) begin
      rd_q[wp_q]   <= bus.ld_rd;
      dat_q[wp_q]  <= bus.ld_data;
      kill_q[wp_q] <= 1'b0;
    end
  end

  function automatic logic [32:0] lookup(
    input logic [4:0] q
  );
    logic [32:0]   r;
    logic [AW-1:0] idx;
    r = '0;
    // Oldest to youngest, so the youngest match wins
    for (int i = 0; i < DEPTH; i++) begin
      idx = rp_q + AW'(i);
      if (CW'(i) < cnt_q && !kill_q[idx]
          && rd_q[idx] == q)
        r = {1'b1, dat_q[idx]};
    end
    if (we3_q && a3_q == q)
      r = {1'b1, wd3_q};
    if (q == 5'd0)
      r = '0;
    return r;
  endfunction

  // Forwarding lookups for both decode read ports
  always_comb begin
    f1 = lookup(bus.q1);
    f2 = lookup(bus.q2);
  end

  assign bus.ld_ready  = !full;
  assign bus.pending   = cnt_q;
  assign bus.we3       = we3_q;
  assign bus.a3        = a3_q;
  assign bus.wd3       = wd3_q;
  assign bus.fwd1_hit  = f1[32];
  assign bus.fwd1_data = f1[31:0];
  assign bus.fwd2_hit  = f2[32];
  assign bus.fwd2_data = f2[31:0];

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: ALU priority, load
// queueing, kill rule, forwarding and reset flush.
module tb_wb_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errs    = 0;
  logic [31:0] rf [32];

  wb_seq_if #(.CW(3)) bus ();

  wb_sequencer #(.DEPTH(4), .CW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.we3 && bus.a3 != 5'd0)
      rf[bus.a3] <= bus.wd3;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic v, input logic [4:0] rd,
                     input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_rd    = rd;
    bus.alu_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd,
                    input logic [31:0] d);
    bus.ld_valid = v;
    bus.ld_rd    = rd;
    bus.ld_data  = d;
  endtask

  task automatic wr(input string tag, input logic we,
                    input logic [4:0] a,
                    input logic [31:0] d);
    chk({tag, ".we3"}, 32'(bus.we3), 32'(we));
    if (we) begin
      chk({tag, ".a3"}, 32'(bus.a3), 32'(a));
      chk({tag, ".wd3"}, bus.wd3, d);
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 32'h0);
    bus.q1 = 5'd0;
    bus.q2 = 5'd0;

    // Reset state
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst.we3", 32'(bus.we3), 32'd0);
    chk("rst.a3", 32'(bus.a3), 32'd0);
    chk("rst.wd3", bus.wd3, 32'd0);
    chk("rst.pending", 32'(bus.pending), 32'd0);
    chk("rst.ld_ready", 32'(bus.ld_ready), 32'd1);

    // 1: single ALU write
    alu(1'b1, 5'd5, 32'hDEADBEEF);
    cyc();
    wr("t1.w", 1'b1, 5'd5, 32'hDEADBEEF);
    alu(1'b0, 5'd0, 32'h0);
    cyc();
    wr("t1.idle", 1'b0, 5'd0, 32'h0);

    // 2: load held behind three ALU cycles
    alu(1'b1, 5'd10, 32'h100);
    ld(1'b1, 5'd7, 32'h11);
    cyc();
    ld(1'b0, 5'd0, 32'h0);
    chk("t2.pending", 32'(bus.pending), 32'd1);
    wr("t2.alu", 1'b1, 5'd10, 32'h100);
    cyc();
    cyc();
    chk("t2.held", 32'(bus.pending), 32'd1);
    alu(1'b0, 5'd0, 32'h0);
    cyc();
    wr("t2.ld", 1'b1, 5'd7, 32'h11);
    chk("t2.drain", 32'(bus.pending), 32'd0);

    // Minimum load latency with an idle ALU
    ld(1'b1, 5'd8, 32'h22);
    cyc();
    ld(1'b0, 5'd0, 32'h0);
    wr("lat.n", 1'b0, 5'd0, 32'h0);
    chk("lat.pending", 32'(bus.pending), 32'd1);
    cyc();
    wr("lat.n2", 1'b1, 5'd8, 32'h22);

    // 3: fill the FIFO, then drain in order
    alu(1'b1, 5'd11, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      ld(1'b1, 5'(k), 32'h1000 + 32'(k));
      cyc();
    end
    chk("t3.full", 32'(bus.pending), 32'd4);
    chk("t3.ready", 32'(bus.ld_ready), 32'd0);
    ld(1'b1, 5'd5, 32'h1005);
    cyc();
    chk("t3.blocked", 32'(bus.pending), 32'd4);
    ld(1'b0, 5'd0, 32'h0);
    alu(1'b0, 5'd0, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      wr("t3.drain", 1'b1, 5'(k), 32'h1000 + 32'(k));
      chk("t3.cnt", 32'(bus.pending), 32'(4 - k));
    end

    // 4: ALU kills a queued load of the same rd
    alu(1'b1, 5'd12, 32'h0);
    ld(1'b1, 5'd9, 32'hAA);
    cyc();
    ld(1'b0, 5'd0, 32'h0);
    alu(1'b1, 5'd9, 32'hBB);
    cyc();
    wr("t4.alu", 1'b1, 5'd9, 32'hBB);
    chk("t4.pending", 32'(bus.pending), 32'd1);
    bus.q1 = 5'd9;
    #1;
    chk("t4.fwd", bus.fwd1_data, 32'hBB);
    alu(1'b0, 5'd0, 32'h0);
    cyc();
    wr("t4.killed", 1'b0, 5'd0, 32'h0);
    cyc();
    chk("t4.rf9", rf[9], 32'hBB);

    // 5: forwarding priority
    alu(1'b1, 5'd12, 32'h0);
    ld(1'b1, 5'd3, 32'h1);
    cyc();
    ld(1'b1, 5'd3, 32'h2);
    cyc();
    ld(1'b0, 5'd0, 32'h0);
    bus.q1 = 5'd3;
    bus.q2 = 5'd0;
    #1;
    chk("t5.hit", 32'(bus.fwd1_hit), 32'd1);
    chk("t5.young", bus.fwd1_data, 32'h2);
    chk("t5.q0hit", 32'(bus.fwd2_hit), 32'd0);
    chk("t5.q0dat", bus.fwd2_data, 32'd0);
    alu(1'b1, 5'd3, 32'h5);
    cyc();
    chk("t5.out", bus.fwd1_data, 32'h5);
    alu(1'b1, 5'd12, 32'h0);
    cyc();
    chk("t5.khit", 32'(bus.fwd1_hit), 32'd0);
    chk("t5.kdat", bus.fwd1_data, 32'd0);
    alu(1'b0, 5'd0, 32'h0);
    cyc();
    wr("t5.pop1", 1'b0, 5'd0, 32'h0);
    cyc();
    wr("t5.pop2", 1'b0, 5'd0, 32'h0);
    chk("t5.empty", 32'(bus.pending), 32'd0);

    // Same-cycle load with the ALU's rd survives
    alu(1'b1, 5'd14, 32'h77);
    ld(1'b1, 5'd14, 32'h88);
    cyc();
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 32'h0);
    wr("same.alu", 1'b1, 5'd14, 32'h77);
    chk("same.pending", 32'(bus.pending), 32'd1);
    cyc();
    wr("same.ld", 1'b1, 5'd14, 32'h88);

    // 6: reset flushes queue and output stage
    alu(1'b1, 5'd12, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      ld(1'b1, 5'(k), 32'h2000 + 32'(k));
      cyc();
    end
    chk("t6.pre", 32'(bus.pending), 32'd3);
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("t6.we3", 32'(bus.we3), 32'd0);
    chk("t6.pending", 32'(bus.pending), 32'd0);
    chk("t6.ready", 32'(bus.ld_ready), 32'd1);
    cyc();
    chk("t6.stale1", 32'(bus.we3), 32'd0);
    cyc();
    chk("t6.stale2", 32'(bus.we3), 32'd0);
    chk("t6.cnt", 32'(bus.pending), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
